ex_issue_ctrl: RTL and testbench



---
 rtl/ex_issue_pkg.sv | 44 ++++
 rtl/ex_issue_fifo.sv | 53 +++++
 rtl/ex_issue_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_pkg.sv
// Shared types and constants for the EX-stage issue driver.
// Operator encodings mirror cv32e40p_pkg so this slice builds on its own.
package ex_issue_pkg;

  localparam int ALU_OP_WIDTH    = 7;
  localparam int MUL_OP_WIDTH    = 3;
  localparam int LAT_WIDTH       = 6;
  localparam int DEFAULT_TIMEOUT = 40;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;

  localparam logic [MUL_OP_WIDTH-1:0] MUL_MAC32 = 3'b000;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_I     = 3'b010;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_H     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } ex_issue_state_e;

  typedef enum logic {
    CMD_ALU  = 1'b0,
    CMD_MULT = 1'b1
  } ex_cmd_kind_e;

  typedef struct packed {
    ex_cmd_kind_e            kind;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [31:0]             a;
    logic [31:0]             b;
    logic [31:0]             c;
    logic [5:0]              waddr;
    logic                    we;
  } ex_cmd_t;

  // Latency counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LAT_WIDTH-1:0] lat_inc(input logic [LAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ex_issue_fifo.sv
// Synchronous command FIFO with wrap-around pointers; the extra pointer bit
// distinguishes full from empty when the index bits match.
module ex_issue_fifo
  import ex_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  ex_cmd_t wdata_i,
  input  logic    pop_i,
  output ex_cmd_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  ex_cmd_t       mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue-side driver for the EX stage: queues ALU/MULT commands, presents them
// through the ex_ready handshake and times the ex_valid completion.
module ex_issue_ctrl
  import ex_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_kind_i,
  input  logic [6:0]  cmd_op_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  input  logic [31:0] cmd_c_i,
  input  logic [5:0]  cmd_waddr_i,
  input  logic        cmd_we_i,
  output logic        alu_en_o,
  output logic        mult_en_o,
  output logic [6:0]  alu_operator_o,
  output logic [2:0]  mult_operator_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  output logic [31:0] alu_operand_c_o,
  output logic [31:0] mult_operand_a_o,
  output logic [31:0] mult_operand_b_o,
  output logic [5:0]  regfile_alu_waddr_o,
  output logic        regfile_alu_we_o,
  input  logic        ex_ready_i,
  input  logic        ex_valid_i,
  output logic        rsp_valid_o,
  output logic [5:0]  rsp_latency_o,
  output logic [5:0]  rsp_waddr_o,
  output logic        timeout_o,
  output logic        busy_o
);

  ex_issue_state_e state_q, state_d;
  logic            alu_en_q, alu_en_d, mult_en_q, mult_en_d;
  logic [6:0]      alu_op_q, alu_op_d;
  logic [2:0]      mult_op_q, mult_op_d;
  logic [31:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic [31:0]     mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [5:0]      waddr_q, waddr_d;
  logic            we_q, we_d;
  logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [5:0]      rsp_lat_q, rsp_lat_d, rsp_waddr_q, rsp_waddr_d;
  logic            timeout_q, timeout_d;

  ex_cmd_t fifo_wdata, head;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty, done;

  assign cmd_ready_o = ~fifo_full & ~rst;
  assign fifo_push   = cmd_valid_i & cmd_ready_o;
  assign fifo_wdata  = '{kind: ex_cmd_kind_e'(cmd_kind_i), op: cmd_op_i, a: cmd_a_i,
                         b: cmd_b_i, c: cmd_c_i, waddr: cmd_waddr_i, we: cmd_we_i};

  ex_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    alu_en_d    = alu_en_q;
    mult_en_d   = mult_en_q;
    alu_op_d    = alu_op_q;
    mult_op_d   = mult_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_lat_d   = rsp_lat_q;
    rsp_waddr_d = rsp_waddr_q;
    timeout_d   = timeout_q;
    fifo_pop    = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      ST_ISSUE: begin
        if (ex_ready_i) begin
          if (ex_valid_i) begin
            rsp_valid_d = 1'b1;
            rsp_lat_d   = '0;
            rsp_waddr_d = waddr_q;
            done        = 1'b1;
          end else begin
            alu_en_d  = 1'b0;
            mult_en_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (ex_valid_i) begin
          rsp_valid_d = 1'b1;
          rsp_lat_d   = lat_inc(cnt_q);
          rsp_waddr_d = waddr_q;
          done        = 1'b1;
        end else if (cnt_q == LAT_WIDTH'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          done      = 1'b1;
        end else begin
          cnt_d = lat_inc(cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        alu_en_d  = 1'b0;
        mult_en_d = 1'b0;
      end
    end

    // Popping loads the head into the EX registers; the idle unit sees zeros.
    if (fifo_pop) begin
      state_d   = ST_ISSUE;
      alu_en_d  = (head.kind == CMD_ALU);
      mult_en_d = (head.kind == CMD_MULT);
      alu_op_d  = '0;
      alu_a_d   = '0;
      alu_b_d   = '0;
      alu_c_d   = '0;
      mult_op_d = '0;
      mult_a_d  = '0;
      mult_b_d  = '0;
      if (head.kind == CMD_ALU) begin
        alu_op_d = head.op;
        alu_a_d  = head.a;
        alu_b_d  = head.b;
        alu_c_d  = head.c;
      end else begin
        mult_op_d = head.op[2:0];
        mult_a_d  = head.a;
        mult_b_d  = head.b;
      end
      waddr_d = head.waddr;
      we_d    = head.we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_en_q    <= 1'b0;
      mult_en_q   <= 1'b0;
      alu_op_q    <= '0;
      mult_op_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lat_q   <= '0;
      rsp_waddr_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_en_q    <= alu_en_d;
      mult_en_q   <= mult_en_d;
      alu_op_q    <= alu_op_d;
      mult_op_q   <= mult_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lat_q   <= rsp_lat_d;
      rsp_waddr_q <= rsp_waddr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign alu_en_o            = alu_en_q;
  assign mult_en_o           = mult_en_q;
  assign alu_operator_o      = alu_op_q;
  assign mult_operator_o     = mult_op_q;
  assign alu_operand_a_o     = alu_a_q;
  assign alu_operand_b_o     = alu_b_q;
  assign alu_operand_c_o     = alu_c_q;
  assign mult_operand_a_o    = mult_a_q;
  assign mult_operand_b_o    = mult_b_q;
  assign regfile_alu_waddr_o = waddr_q;
  assign regfile_alu_we_o    = we_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_latency_o       = rsp_lat_q;
  assign rsp_waddr_o         = rsp_waddr_q;
  assign timeout_o           = timeout_q;
  assign busy_o              = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Scoreboard bench for ex_issue_ctrl: directed commands push expected issues
// and responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ex_issue_ctrl;
  import ex_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o;
  logic        cmd_kind_i = 1'b0;
  logic [6:0]  cmd_op_i = '0;
  logic [31:0] cmd_a_i = '0, cmd_b_i = '0, cmd_c_i = '0;
  logic [5:0]  cmd_waddr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic        alu_en_o, mult_en_o;
  logic [6:0]  alu_operator_o;
  logic [2:0]  mult_operator_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_operand_c_o;
  logic [31:0] mult_operand_a_o, mult_operand_b_o;
  logic [5:0]  regfile_alu_waddr_o;
  logic        regfile_alu_we_o;
  logic        ex_ready_i = 1'b0, ex_valid_i = 1'b0;
  logic        rsp_valid_o;
  logic [5:0]  rsp_latency_o, rsp_waddr_o;
  logic        timeout_o, busy_o;

  ex_issue_ctrl #(.DEPTH(4), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_kind_i(cmd_kind_i),
    .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_c_i(cmd_c_i),
    .cmd_waddr_i(cmd_waddr_i), .cmd_we_i(cmd_we_i),
    .alu_en_o(alu_en_o), .mult_en_o(mult_en_o),
    .alu_operator_o(alu_operator_o), .mult_operator_o(mult_operator_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_operand_c_o(alu_operand_c_o),
    .mult_operand_a_o(mult_operand_a_o), .mult_operand_b_o(mult_operand_b_o),
    .regfile_alu_waddr_o(regfile_alu_waddr_o), .regfile_alu_we_o(regfile_alu_we_o),
    .ex_ready_i(ex_ready_i), .ex_valid_i(ex_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_latency_o(rsp_latency_o), .rsp_waddr_o(rsp_waddr_o),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] lat;
    logic [5:0] waddr;
  } rsp_t;

  logic [191:0] iss_q[$];
  rsp_t         rsp_q[$];
  rsp_t         mon_r;
  logic [191:0] mon_e;
  int total = 0;
  int bad = 0;
  int en_cycles = 0;

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Everything EX should see for one command, as a flat vector.
  function automatic logic [191:0] expIssue(input logic kind, input logic [6:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [5:0] waddr,
                                            input logic we);
    if (!kind) return {13'd0, 1'b1, 1'b0, op, a, b, c, 3'd0, 32'd0, 32'd0, waddr, we};
    return {13'd0, 1'b0, 1'b1, 7'd0, 96'd0, op[2:0], a, b, waddr, we};
  endfunction

  function automatic logic [191:0] actIssue();
    return {13'd0, alu_en_o, mult_en_o, alu_operator_o, alu_operand_a_o, alu_operand_b_o,
            alu_operand_c_o, mult_operator_o, mult_operand_a_o, mult_operand_b_o,
            regfile_alu_waddr_o, regfile_alu_we_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic kind, input logic [6:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c,
                               input logic [5:0] waddr, input logic we, input bit exp_issue,
                               input bit exp_rsp, input logic [5:0] exp_lat);
    int guard;
    rsp_t r;
    guard = 0;
    cmd_kind_i  = kind;
    cmd_op_i    = op;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_c_i     = c;
    cmd_waddr_i = waddr;
    cmd_we_i    = we;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && guard < 100) begin
      tick(1);
      guard++;
    end
    if (!cmd_ready_o) begin
      total++;
      bad++;
      $display("[TB] FAIL push_wait: cmd_ready_o=%0b after %0d cycles, required 1", cmd_ready_o, guard);
      cmd_valid_i = 1'b0;
    end else begin
      if (exp_issue) iss_q.push_back(expIssue(kind, op, a, b, c, waddr, we));
      if (exp_rsp) begin
        r.lat   = exp_lat;
        r.waddr = waddr;
        rsp_q.push_back(r);
      end
      tick(1);
      cmd_valid_i = 1'b0;
    end
  endtask

  // Monitor: pops an expected issue on every accept, an expected response on every pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_en_o || mult_en_o) begin
        en_cycles++;
        checkOutput("en_exclusive", 192'(alu_en_o & mult_en_o), 192'(0));
      end
      if ((alu_en_o || mult_en_o) && ex_ready_i) begin
        if (iss_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL issue_unexpected: got %0h expected nothing", actIssue());
        end else begin
          mon_e = iss_q.pop_front();
          checkOutput("issue_fields", actIssue(), mon_e);
        end
      end
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rsp_unexpected: got waddr %0d latency %0d expected none",
                   rsp_waddr_o, rsp_latency_o);
        end else begin
          mon_r = rsp_q.pop_front();
          checkOutput("rsp_latency", 192'(rsp_latency_o), 192'(mon_r.lat));
          checkOutput("rsp_waddr", 192'(rsp_waddr_o), 192'(mon_r.waddr));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while rst is held, then cmd_ready after release.
    #2;
    checkOutput("rst_cmd_ready", 192'(cmd_ready_o), 192'(0));
    checkOutput("rst_ex_outputs", actIssue(), 192'(0));
    checkOutput("rst_rsp", 192'({rsp_valid_o, rsp_latency_o, rsp_waddr_o}), 192'(0));
    checkOutput("rst_flags", 192'({timeout_o, busy_o}), 192'(0));
    tick(2);
    rst = 1'b0;
    #1;
    checkOutput("rel_cmd_ready", 192'(cmd_ready_o), 192'(1));

    // ALU_ADD with an immediately ready/valid EX; ex_valid in IDLE must be ignored.
    $display("[TB] single-cycle ALU_ADD");
    ex_ready_i = 1'b1;
    ex_valid_i = 1'b1;
    tick(2);
    en_cycles = 0;
    applyStimulus(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd0, 6'd3, 1'b1, 1'b1, 1'b1, 6'd0);
    tick(1);
    checkOutput("t1_en_after_n1", 192'(alu_en_o), 192'(1));
    tick(1);
    checkOutput("t1_en_drop", 192'(alu_en_o), 192'(0));
    checkOutput("t1_rsp_pulse", 192'(rsp_valid_o), 192'(1));
    tick(1);
    checkOutput("t1_rsp_one_cycle", 192'(rsp_valid_o), 192'(0));
    checkOutput("t1_en_cycles", 192'(en_cycles), 192'(1));

    // ALU_DIVU answered 34 cycles after accept.
    $display("[TB] multi-cycle ALU_DIVU");
    ex_valid_i = 1'b0;
    en_cycles = 0;
    applyStimulus(1'b0, ALU_DIVU, 32'd100, 32'd7, 32'd0, 6'd9, 1'b1, 1'b1, 1'b1, 6'd34);
    tick(2);
    checkOutput("t2_en_dropped", 192'(alu_en_o), 192'(0));
    checkOutput("t2_busy", 192'(busy_o), 192'(1));
    tick(33);
    checkOutput("t2_no_early_rsp", 192'(rsp_valid_o), 192'(0));
    ex_valid_i = 1'b1;
    tick(1);
    ex_valid_i = 1'b0;
    checkOutput("t2_rsp_pulse", 192'(rsp_valid_o), 192'(1));
    checkOutput("t2_latency", 192'(rsp_latency_o), 192'(34));
    checkOutput("t2_en_cycles", 192'(en_cycles), 192'(1));

    // EX stalls 3 cycles; enable and operands held, accept on the 4th.
    $display("[TB] ex_ready stall");
    ex_ready_i = 1'b0;
    ex_valid_i = 1'b1;
    en_cycles = 0;
    applyStimulus(1'b0, ALU_SUB, 32'd100, 32'd1, 32'd2, 6'd12, 1'b0, 1'b1, 1'b1, 6'd0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_hold_en", 192'(alu_en_o), 192'(1));
      checkOutput("t3_hold_a", 192'(alu_operand_a_o), 192'(100));
      tick(1);
    end
    checkOutput("t3_en_4th", 192'(alu_en_o), 192'(1));
    ex_ready_i = 1'b1;
    tick(1);
    checkOutput("t3_en_drop", 192'(alu_en_o), 192'(0));
    checkOutput("t3_rsp_pulse", 192'(rsp_valid_o), 192'(1));
    checkOutput("t3_en_cycles", 192'(en_cycles), 192'(4));
    ex_valid_i = 1'b0;

    // One command stuck in ISSUE, four more fill the FIFO, then drain back-to-back.
    $display("[TB] fifo fill and back-to-back drain");
    ex_ready_i = 1'b0;
    applyStimulus(1'b0, ALU_ADD, 32'd1, 32'd2, 32'd0, 6'd1, 1'b1, 1'b1, 1'b1, 6'd0);
    tick(2);
    applyStimulus(1'b1, {4'd0, MUL_I}, 32'd3, 32'd4, 32'd0, 6'd2, 1'b1, 1'b1, 1'b1, 6'd0);
    applyStimulus(1'b0, ALU_SUB, 32'd9, 32'd8, 32'd7, 6'd3, 1'b0, 1'b1, 1'b1, 6'd0);
    applyStimulus(1'b1, {4'd0, MUL_MAC32}, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 6'd4, 1'b1,
                  1'b1, 1'b1, 6'd0);
    checkOutput("t4_ready_3_in_fifo", 192'(cmd_ready_o), 192'(1));
    applyStimulus(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd5, 6'd5, 1'b1, 1'b1, 1'b1, 6'd0);
    checkOutput("t4_full_not_ready", 192'(cmd_ready_o), 192'(0));
    cmd_kind_i  = 1'b0;
    cmd_op_i    = ALU_ADD;
    cmd_a_i     = 32'd77;
    cmd_waddr_i = 6'd60;
    cmd_valid_i = 1'b1;
    tick(2);
    cmd_valid_i = 1'b0;
    checkOutput("t4_still_full", 192'(cmd_ready_o), 192'(0));
    en_cycles = 0;
    ex_ready_i = 1'b1;
    ex_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_b2b_en", 192'(alu_en_o | mult_en_o), 192'(1));
      tick(1);
      checkOutput("t4_b2b_rsp", 192'(rsp_valid_o), 192'(1));
    end
    checkOutput("t4_drained_en", 192'(alu_en_o | mult_en_o), 192'(0));
    checkOutput("t4_drained_busy", 192'(busy_o), 192'(0));
    checkOutput("t4_en_cycles", 192'(en_cycles), 192'(5));
    ex_valid_i = 1'b0;

    // MUL_H never answered: abort after 40 cycles, then the queued ALU issues.
    $display("[TB] timeout");
    applyStimulus(1'b1, {4'd0, MUL_H}, 32'd6, 32'd7, 32'd0, 6'd20, 1'b1, 1'b1, 1'b0, 6'd0);
    applyStimulus(1'b0, ALU_ADD, 32'd11, 32'd22, 32'd0, 6'd21, 1'b1, 1'b1, 1'b1, 6'd0);
    tick(40);
    checkOutput("t5_no_timeout_yet", 192'(timeout_o), 192'(0));
    tick(1);
    checkOutput("t5_timeout_set", 192'(timeout_o), 192'(1));
    checkOutput("t5_next_issued", 192'({alu_en_o, mult_en_o}), 192'(2'b10));
    checkOutput("t5_no_rsp_on_abort", 192'(rsp_valid_o), 192'(0));
    ex_valid_i = 1'b1;
    tick(1);
    ex_valid_i = 1'b0;
    checkOutput("t5_next_rsp", 192'(rsp_valid_o), 192'(1));
    tick(1);
    checkOutput("t5_timeout_sticky", 192'(timeout_o), 192'(1));

    // Reset while WAIT with two commands queued: they are discarded.
    $display("[TB] reset mid-operation");
    ex_ready_i = 1'b1;
    applyStimulus(1'b0, ALU_DIVU, 32'd50, 32'd5, 32'd0, 6'd30, 1'b1, 1'b1, 1'b0, 6'd0);
    applyStimulus(1'b0, ALU_ADD, 32'd1, 32'd1, 32'd0, 6'd31, 1'b1, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, ALU_ADD, 32'd2, 32'd2, 32'd0, 6'd32, 1'b1, 1'b0, 1'b0, 6'd0);
    tick(2);
    checkOutput("t6_busy_wait", 192'(busy_o), 192'(1));
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_ex_outputs", actIssue(), 192'(0));
    checkOutput("t6_rst_rsp", 192'({rsp_valid_o, rsp_latency_o, rsp_waddr_o}), 192'(0));
    checkOutput("t6_rst_flags", 192'({timeout_o, busy_o, cmd_ready_o}), 192'(0));
    tick(1);
    ex_ready_i = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("t6_rel_busy", 192'(busy_o), 192'(0));
    checkOutput("t6_rel_ready", 192'(cmd_ready_o), 192'(1));
    tick(3);
    checkOutput("t6_fifo_flushed", 192'({alu_en_o, busy_o}), 192'(0));

    checkOutput("end_issue_queue", 192'(iss_q.size()), 192'(0));
    checkOutput("end_rsp_queue", 192'(rsp_q.size()), 192'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
